instr_fetch_unit: RTL and testbench



---
 rtl/rv_pkg.sv | 21 ++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: fetch FSM encoding, NOP word and base opcodes.
package rv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'd19;
  localparam logic [6:0] LOAD   = 7'd3;
  localparam logic [6:0] STORE  = 7'd35;
  localparam logic [6:0] BRANCH = 7'd99;
  localparam logic [6:0] JAL    = 7'd111;
  localparam logic [6:0] JALR   = 7'd103;
  localparam logic [6:0] LUI    = 7'd55;
  localparam logic [6:0] OP     = 7'd51;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/gnt/rvalid fetch,
// output instruction register with valid/ready handshake and PC redirect.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            id_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc_out,
  output logic [6:0]      opcode
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc_q, w_pc_nxt;
  logic [XLEN-1:0] r_pc_out, w_pc_out_nxt;
  logic [31:0]     r_instr, w_instr_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_discard, w_discard_nxt;
  logic            w_slot_free;
  logic            w_req;
  logic            w_fire;
  logic [XLEN-1:0] w_redirect_tgt;

  assign w_slot_free    = !r_valid || id_ready;
  assign w_req          = (r_state == ST_FETCH) && w_slot_free;
  assign w_fire         = w_req && imem_gnt;
  assign w_redirect_tgt = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pc_q    <= RESET_PC;
      r_pc_out  <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc_q    <= w_pc_nxt;
      r_pc_out  <= w_pc_out_nxt;
      r_instr   <= w_instr_nxt;
      r_valid   <= w_valid_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc_q;
    w_pc_out_nxt  = r_pc_out;
    w_instr_nxt   = r_instr;
    w_valid_nxt   = r_valid;
    w_discard_nxt = r_discard;

    // Decode consumed the held instruction; a response below may overwrite this.
    if (r_valid && id_ready) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
    end

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_fire) begin
          w_state_nxt = ST_WAIT;
        end
        // A grant in the redirect cycle is still honoured, so its data must be dropped.
        if (redirect) begin
          w_pc_nxt    = w_redirect_tgt;
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          if (w_fire) begin
            w_discard_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          w_pc_nxt    = w_redirect_tgt;
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          if (imem_rvalid) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = ST_FETCH;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          w_state_nxt = ST_FETCH;
          if (r_discard) begin
            w_discard_nxt = 1'b0;
          end else begin
            w_instr_nxt  = imem_rdata;
            w_pc_out_nxt = r_pc_q;
            w_valid_nxt  = 1'b1;
            w_pc_nxt     = r_pc_q + XLEN'(4);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc_q;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign pc_out      = r_pc_out;
  assign opcode      = r_instr[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed per-cycle vector bench for instr_fetch_unit with a small latency-programmable imem model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        id_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [6:0]  opcode;

  logic        gnt_en;
  int          lat;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  int n_vec;
  int n_fail;

  typedef struct {
    logic        id_ready;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt_en;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  instr_fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .id_ready(id_ready),
    .instr(instr),
    .pc_out(pc_out),
    .opcode(opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[24:0], 7'd51};
  endfunction

  assign imem_gnt = imem_req & gnt_en;

  // Memory model: response arrives lat cycles after the granting cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
      pend        <= 1'b0;
      pend_cnt    <= 0;
      pend_addr   <= 32'h0;
    end else begin
      imem_rvalid <= 1'b0;
      if (imem_req && imem_gnt) begin
        if (lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(imem_addr);
        end else begin
          pend      <= 1'b1;
          pend_cnt  <= lat - 1;
          pend_addr <= imem_addr;
        end
      end else if (pend) begin
        if (pend_cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(pend_addr);
          pend        <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
    end
  end

  function automatic vec_t v(input logic idr, input logic rd, input logic [31:0] rpc,
                             input logic ge, input int l, input logic er,
                             input logic [31:0] ea, input logic ev,
                             input logic [31:0] ei, input logic [31:0] ep);
    vec_t t;
    t.id_ready = idr; t.redir = rd; t.rpc = rpc; t.gnt_en = ge; t.lat = l;
    t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_instr = ei; t.e_pc = ep;
    return t;
  endfunction

  task automatic check(input string name, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ei, input logic chk_pc,
                       input logic [31:0] ep);
    logic ok;
    n_vec++;
    ok = (imem_req === er) && (imem_addr === ea) && (instr_valid === ev) &&
         (instr === ei) && (opcode === ei[6:0]) && (!chk_pc || (pc_out === ep));
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h op=%0d pc=%h, want req=%b addr=%h valid=%b instr=%h op=%0d pc=%h",
               name, imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
               er, ea, ev, ei, ei[6:0], ep);
    end
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    rst_n = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    gnt_en = 1'b1; lat = 1;

    // cycle-by-cycle after reset release
    vq.push_back(v(1,0,0,1,1, 0,32'h0,0,NOP,0));                 // c0 IDLE
    vq.push_back(v(1,0,0,1,1, 1,32'h0,0,NOP,0));                 // c1 req @0
    vq.push_back(v(1,0,0,1,1, 0,32'h0,0,NOP,0));                 // c2 wait
    for (int i = 0; i < 5; i++)
      vq.push_back(v(0,0,0,1,1, 0,32'h4,1,32'h0050_0093,32'h0)); // c3-7 stall
    vq.push_back(v(1,0,0,1,1, 1,32'h4,1,32'h0050_0093,32'h0));   // c8 resume
    vq.push_back(v(1,0,0,1,1, 0,32'h4,0,NOP,0));                 // c9
    vq.push_back(v(1,0,0,1,3, 1,32'h8,1,32'h0000_0233,32'h4));   // c10 gnt @8 lat3
    vq.push_back(v(1,1,32'h100,1,3, 0,32'h8,0,NOP,0));           // c11 redirect in WAIT
    vq.push_back(v(1,0,0,1,1, 0,32'h100,0,NOP,0));               // c12
    vq.push_back(v(1,0,0,1,1, 0,32'h100,0,NOP,0));               // c13 stale rvalid dropped
    vq.push_back(v(1,0,0,1,1, 1,32'h100,0,NOP,0));               // c14 req @100
    vq.push_back(v(1,0,0,1,1, 0,32'h100,0,NOP,0));               // c15
    vq.push_back(v(1,0,0,1,1, 1,32'h104,1,32'h0000_8033,32'h100)); // c16
    vq.push_back(v(1,1,32'h102,1,1, 0,32'h104,0,NOP,0));         // c17 redirect + rvalid
    vq.push_back(v(1,1,32'hFFFF_FFFF,1,1, 1,32'h100,0,NOP,0));   // c18 redirect + gnt
    vq.push_back(v(1,0,0,1,1, 0,32'hFFFF_FFFC,0,NOP,0));         // c19 discard
    vq.push_back(v(1,0,0,1,1, 1,32'hFFFF_FFFC,0,NOP,0));         // c20
    vq.push_back(v(1,0,0,1,1, 0,32'hFFFF_FFFC,0,NOP,0));         // c21
    vq.push_back(v(1,0,0,0,1, 1,32'h0,1,32'hFFFF_FE33,32'hFFFF_FFFC)); // c22 wrap
    vq.push_back(v(0,1,32'h40,0,1, 1,32'h0,0,NOP,0));            // c23 redirect, no gnt
    vq.push_back(v(0,0,0,0,1, 1,32'h40,0,NOP,0));                // c24 addr moves
    vq.push_back(v(0,0,0,1,3, 1,32'h40,0,NOP,0));                // c25 gnt lat3
    vq.push_back(v(0,0,0,1,3, 0,32'h40,0,NOP,0));                // c26 WAIT

    repeat (2) @(negedge clk);
    check("reset", 1'b0, 32'h0, 1'b0, NOP, 1'b1, 32'h0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      id_ready    = vq[i].id_ready;
      redirect    = vq[i].redir;
      redirect_pc = vq[i].rpc;
      gnt_en      = vq[i].gnt_en;
      lat         = vq[i].lat;
      #1;
      check($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_valid,
            vq[i].e_instr, vq[i].e_valid, vq[i].e_pc);
      @(negedge clk);
    end

    // Asynchronous reset while a request is outstanding
    id_ready = 1'b1; redirect = 1'b0; gnt_en = 1'b0; lat = 1;
    #2 rst_n = 1'b0;
    #1 check("async_rst", 1'b0, 32'h0, 1'b0, NOP, 1'b1, 32'h0);
    @(negedge clk);
    check("rst_hold", 1'b0, 32'h0, 1'b0, NOP, 1'b1, 32'h0);
    rst_n = 1'b1;
    #1 check("rst_idle", 1'b0, 32'h0, 1'b0, NOP, 1'b1, 32'h0);
    @(negedge clk);
    #1 check("rst_first_req", 1'b1, 32'h0, 1'b0, NOP, 1'b0, 32'h0);
    if (imem_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_stale: rvalid=%b want 0", imem_rvalid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
